// File: rtl/ad7606_pkg.sv
// Types and helpers shared by the AD7606 controller and its downstream averaging block.
package ad7606_pkg;

    localparam int NUM_CH = 8;

    typedef enum logic [1:0] {StIdle, StAccum, StOut} state_e;

    // Sign-extend the low w bits of x to 32 bits.
    function automatic logic [31:0] sext(input logic [31:0] x, input int unsigned w);
        logic signed [31:0] t;
        t = x << (32 - w);
        return t >>> (32 - w);
    endfunction

endpackage

// File: rtl/ad7606_avg.sv
// Box-car averager over 2^AVG_LOG2 AD7606 frames; one shared adder walks the eight
// channels per frame, then the averages stream out channel 0 first.
module ad7606_avg
    import ad7606_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned AVG_LOG2 = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_ch1,
    input  logic [DATA_W-1:0] in_ch2,
    input  logic [DATA_W-1:0] in_ch3,
    input  logic [DATA_W-1:0] in_ch4,
    input  logic [DATA_W-1:0] in_ch5,
    input  logic [DATA_W-1:0] in_ch6,
    input  logic [DATA_W-1:0] in_ch7,
    input  logic [DATA_W-1:0] in_ch8,
    input  logic              in_vd,
    input  logic              clr,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_ch,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic [7:0]        ovr_cnt,
    output logic              ovr
);

    localparam int unsigned ACC_W  = DATA_W + AVG_LOG2;
    localparam int unsigned FCNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'((1 << AVG_LOG2) - 1);

    state_e             state_q, state_d;
    logic [FCNT_W-1:0]  fcnt_q;
    logic [2:0]         idx_q;
    logic [DATA_W-1:0]  shadow_q [NUM_CH];
    logic [ACC_W-1:0]   acc_q    [NUM_CH];
    logic [ACC_W-1:0]   sum;
    logic [2:0]         next_ch;
    logic               capture, overrun, beat, win_done;

    assign beat     = out_valid && out_ready;
    assign win_done = (fcnt_q == FCNT_LAST);
    assign next_ch  = out_ch + 3'd1;

    // First frame of a window overwrites the accumulator instead of adding to it.
    assign sum = ((fcnt_q == '0) ? '0 : acc_q[idx_q])
               + ACC_W'(sext(32'(shadow_q[idx_q]), DATA_W));

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        overrun = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_vd) begin
                    capture = 1'b1;
                    state_d = StAccum;
                end
            end
            StAccum: begin
                overrun = in_vd;
                if (idx_q == 3'd7) begin
                    state_d = win_done ? StOut : StIdle;
                end
            end
            StOut: begin
                overrun = in_vd;
                if (beat && out_ch == 3'd7) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (clr) begin
            state_d = StIdle;
            capture = 1'b0;
            overrun = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            fcnt_q    <= '0;
            idx_q     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ovr       <= 1'b0;
            ovr_cnt   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ovr     <= overrun;
            if (clr) begin
                fcnt_q    <= '0;
                idx_q     <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                out_ch    <= '0;
                ovr_cnt   <= '0;
            end else begin
                if (overrun && ovr_cnt != 8'hff) begin
                    ovr_cnt <= ovr_cnt + 8'd1;
                end
                if (capture) begin
                    shadow_q[0] <= in_ch1;
                    shadow_q[1] <= in_ch2;
                    shadow_q[2] <= in_ch3;
                    shadow_q[3] <= in_ch4;
                    shadow_q[4] <= in_ch5;
                    shadow_q[5] <= in_ch6;
                    shadow_q[6] <= in_ch7;
                    shadow_q[7] <= in_ch8;
                    idx_q       <= '0;
                end
                if (state_q == StAccum) begin
                    acc_q[idx_q] <= sum;
                    idx_q        <= idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        if (win_done) begin
                            fcnt_q    <= '0;
                            out_valid <= 1'b1;
                            out_ch    <= '0;
                            out_last  <= 1'b0;
                            // Channel 0 finished seven cycles ago, so it is safe to read here.
                            out_data  <= acc_q[0][AVG_LOG2 +: DATA_W];
                        end else begin
                            fcnt_q <= fcnt_q + FCNT_W'(1);
                        end
                    end
                end
                if (beat) begin
                    if (out_ch == 3'd7) begin
                        out_valid <= 1'b0;
                        out_ch    <= '0;
                        out_last  <= 1'b0;
                    end else begin
                        out_ch   <= next_ch;
                        out_data <= acc_q[next_ch][AVG_LOG2 +: DATA_W];
                        out_last <= (next_ch == 3'd7);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ad7606_avg.sv
// Directed bench: a pass-through instance and a 4-frame averaging instance share stimulus.
module tb_ad7606_avg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_ch1, in_ch2, in_ch3, in_ch4, in_ch5, in_ch6, in_ch7, in_ch8;
    logic        in_vd = 1'b0;
    logic        clr = 1'b0;
    logic        out_ready = 1'b1;

    logic [15:0] p_data, a_data;
    logic [2:0]  p_ch, a_ch;
    logic        p_valid, a_valid, p_last, a_last, p_ovr, a_ovr;
    logic [7:0]  p_ovr_cnt, a_ovr_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ad7606_avg #(.DATA_W(16), .AVG_LOG2(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_ch1(in_ch1), .in_ch2(in_ch2), .in_ch3(in_ch3), .in_ch4(in_ch4),
        .in_ch5(in_ch5), .in_ch6(in_ch6), .in_ch7(in_ch7), .in_ch8(in_ch8),
        .in_vd(in_vd), .clr(clr),
        .out_data(p_data), .out_ch(p_ch), .out_valid(p_valid), .out_last(p_last),
        .out_ready(out_ready), .ovr_cnt(p_ovr_cnt), .ovr(p_ovr)
    );

    ad7606_avg #(.DATA_W(16), .AVG_LOG2(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_ch1(in_ch1), .in_ch2(in_ch2), .in_ch3(in_ch3), .in_ch4(in_ch4),
        .in_ch5(in_ch5), .in_ch6(in_ch6), .in_ch7(in_ch7), .in_ch8(in_ch8),
        .in_vd(in_vd), .clr(clr),
        .out_data(a_data), .out_ch(a_ch), .out_valid(a_valid), .out_last(a_last),
        .out_ready(out_ready), .ovr_cnt(a_ovr_cnt), .ovr(a_ovr)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        in_vd = 1'b0;
        clr = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drives one in_vd cycle from a negedge; returns at the following negedge.
    task automatic send_frame(input logic [15:0] v [8]);
        in_ch1 = v[0]; in_ch2 = v[1]; in_ch3 = v[2]; in_ch4 = v[3];
        in_ch5 = v[4]; in_ch6 = v[5]; in_ch7 = v[6]; in_ch8 = v[7];
        in_vd = 1'b1;
        @(negedge clk);
        in_vd = 1'b0;
    endtask

    task automatic gap(output bit seen);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= a_valid;
        end
    endtask

    // Called right after send_frame; cyc is the cycle index of the first valid.
    task automatic wait_a_valid(output int cyc);
        cyc = 1;
        while (!a_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", a_valid); end
        checks++; if (a_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", a_last); end
        checks++; if (a_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0", a_data); end
        checks++; if (a_ch !== 3'd0) begin errors++; $display("FAIL reset_ch: got %0d want 0", a_ch); end
        checks++; if (a_ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", a_ovr); end
        checks++; if (a_ovr_cnt !== 8'd0) begin errors++; $display("FAIL reset_ovr_cnt: got %0d want 0", a_ovr_cnt); end
        checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL reset_p_valid: got %b want 0", p_valid); end
    endtask

    task automatic test_passthrough();
        logic [15:0] v [8];
        int cyc;
        do_reset();
        v = '{16'h0001, 16'hFFFF, 16'd100, 16'hFF9C, 16'h7FFF, 16'h8000, 16'h0000, 16'h0005};
        send_frame(v);
        cyc = 1;
        while (!p_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc != 9) begin errors++; $display("FAIL pt_latency: got %0d want 9", cyc); end
        for (int b = 0; b < 8; b++) begin
            checks++; if (p_data !== v[b]) begin errors++; $display("FAIL pt_data[%0d]: got %h want %h", b, p_data, v[b]); end
            checks++; if (p_ch !== 3'(b)) begin errors++; $display("FAIL pt_ch[%0d]: got %0d want %0d", b, p_ch, b); end
            checks++; if (p_last !== (b == 7)) begin errors++; $display("FAIL pt_last[%0d]: got %b want %b", b, p_last, b == 7); end
            @(negedge clk);
        end
        checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL pt_end_valid: got %b want 0", p_valid); end
    endtask

    task automatic test_average();
        logic [15:0] f [4][8];
        logic [15:0] exp [8];
        logic [15:0] v [8];
        bit seen;
        int cyc;
        do_reset();
        f[0] = '{16'd10, 16'hFFFF, 16'd100, 16'hFFFB, 16'h7FFF, 16'h8000, 16'd0, 16'd7};
        f[1] = '{16'd11, 16'hFFFF, 16'd200, 16'hFFFA, 16'h7FFF, 16'h8000, 16'd1, 16'd7};
        f[2] = '{16'd12, 16'hFFFF, 16'd300, 16'hFFF9, 16'h7FFF, 16'h8000, 16'd2, 16'd7};
        f[3] = '{16'd13, 16'hFFFE, 16'd400, 16'hFFF8, 16'h7FFF, 16'h8000, 16'd0, 16'd6};
        exp  = '{16'd11, 16'hFFFE, 16'd250, 16'hFFF9, 16'h7FFF, 16'h8000, 16'd0, 16'd6};
        for (int i = 0; i < 3; i++) begin
            v = f[i];
            send_frame(v);
            gap(seen);
            checks++; if (seen) begin errors++; $display("FAIL avg_early_out[%0d]: got valid want none", i); end
        end
        v = f[3];
        send_frame(v);
        wait_a_valid(cyc);
        checks++; if (cyc != 9) begin errors++; $display("FAIL avg_latency: got %0d want 9", cyc); end
        for (int b = 0; b < 8; b++) begin
            checks++; if (a_data !== exp[b] || a_ch !== 3'(b) || a_valid !== 1'b1) begin
                errors++; $display("FAIL avg_beat[%0d]: got %h ch %0d v %b want %h ch %0d v 1", b, a_data, a_ch, a_valid, exp[b], b);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] v [8];
        logic [15:0] held_d;
        logic [2:0]  held_c;
        int pat [4] = '{1, 0, 0, 1};
        bit seen, stalled;
        int cyc, beat, p;
        do_reset();
        v = '{16'hFED4, 16'hFF38, 16'hFF9C, 16'd0, 16'd100, 16'd200, 16'd300, 16'd400};
        for (int i = 0; i < 4; i++) begin
            send_frame(v);
            if (i < 3) gap(seen);
        end
        out_ready = 1'b0;
        wait_a_valid(cyc);
        beat = 0; stalled = 1'b0; p = 0; held_d = '0; held_c = '0;
        for (int c = 0; c < 60 && beat < 8; c++) begin
            if (stalled) begin
                checks++; if (a_valid !== 1'b1 || a_data !== held_d || a_ch !== held_c) begin
                    errors++; $display("FAIL bp_hold: got %h ch %0d v %b want %h ch %0d v 1", a_data, a_ch, a_valid, held_d, held_c);
                end
            end
            out_ready = pat[p % 4] != 0;
            p++;
            stalled = 1'b0;
            if (a_valid) begin
                if (out_ready) begin
                    checks++; if (a_data !== v[beat] || a_ch !== 3'(beat) || a_last !== (beat == 7)) begin
                        errors++; $display("FAIL bp_beat[%0d]: got %h ch %0d last %b want %h ch %0d", beat, a_data, a_ch, a_last, v[beat], beat);
                    end
                    beat++;
                end else begin
                    stalled = 1'b1; held_d = a_data; held_c = a_ch;
                end
            end
            @(negedge clk);
        end
        checks++; if (beat != 8) begin errors++; $display("FAIL bp_count: got %0d want 8", beat); end
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL bp_extra: got valid %b want 0", a_valid); end
        out_ready = 1'b1;
    endtask

    task automatic test_overrun();
        logic [15:0] v [8];
        do_reset();
        v = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        send_frame(v);                 // now in cycle 1
        repeat (2) @(negedge clk);     // cycle 3, mid-ACCUM
        send_frame(v);
        checks++; if (a_ovr !== 1'b1) begin errors++; $display("FAIL ovr_pulse: got %b want 1", a_ovr); end
        checks++; if (a_ovr_cnt !== 8'd1) begin errors++; $display("FAIL ovr_cnt1: got %0d want 1", a_ovr_cnt); end
        @(negedge clk);
        checks++; if (a_ovr !== 1'b0) begin errors++; $display("FAIL ovr_one_cycle: got %b want 0", a_ovr); end
        repeat (3) @(negedge clk);     // cycle 8, last ACCUM cycle
        send_frame(v);
        checks++; if (a_ovr !== 1'b1 || a_ovr_cnt !== 8'd2) begin
            errors++; $display("FAIL ovr_last_accum: got ovr %b cnt %0d want 1 2", a_ovr, a_ovr_cnt);
        end
        @(negedge clk);                // cycle 10, idle
        send_frame(v);
        checks++; if (a_ovr !== 1'b0 || a_ovr_cnt !== 8'd2) begin
            errors++; $display("FAIL ovr_accepted: got ovr %b cnt %0d want 0 2", a_ovr, a_ovr_cnt);
        end
        repeat (12) @(negedge clk);
        in_vd = 1'b1;
        repeat (400) @(negedge clk);
        in_vd = 1'b0;
        repeat (30) @(negedge clk);
        checks++; if (a_ovr_cnt !== 8'd255) begin errors++; $display("FAIL ovr_saturate: got %0d want 255", a_ovr_cnt); end
    endtask

    task automatic test_clear();
        logic [15:0] v [8];
        bit seen;
        int cyc;
        do_reset();
        for (int i = 0; i < 8; i++) v[i] = 16'd1000;
        send_frame(v);
        repeat (2) @(negedge clk);
        send_frame(v);                 // dropped, bumps ovr_cnt
        gap(seen);
        send_frame(v);
        gap(seen);
        checks++; if (a_ovr_cnt !== 8'd1) begin errors++; $display("FAIL clr_pre_cnt: got %0d want 1", a_ovr_cnt); end
        clr = 1'b1;
        in_vd = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        in_vd = 1'b0;
        checks++; if (a_ovr !== 1'b0 || a_ovr_cnt !== 8'd0) begin
            errors++; $display("FAIL clr_ovr: got ovr %b cnt %0d want 0 0", a_ovr, a_ovr_cnt);
        end
        for (int i = 0; i < 8; i++) v[i] = 16'd8;
        for (int i = 0; i < 3; i++) begin
            send_frame(v);
            gap(seen);
            checks++; if (seen) begin errors++; $display("FAIL clr_early_out[%0d]: got valid want none", i); end
        end
        send_frame(v);
        wait_a_valid(cyc);
        checks++; if (cyc != 9) begin errors++; $display("FAIL clr_latency: got %0d want 9", cyc); end
        for (int b = 0; b < 8; b++) begin
            checks++; if (a_data !== 16'd8 || a_ch !== 3'(b)) begin
                errors++; $display("FAIL clr_beat[%0d]: got %h ch %0d want 0008 ch %0d", b, a_data, a_ch, b);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] v [8];
        bit seen;
        int cyc;
        do_reset();
        v = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        for (int i = 0; i < 4; i++) begin
            send_frame(v);
            if (i < 3) gap(seen);
        end
        wait_a_valid(cyc);
        repeat (3) @(negedge clk);
        checks++; if (a_valid !== 1'b1 || a_ch !== 3'd3) begin
            errors++; $display("FAIL ar_pre: got v %b ch %0d want 1 3", a_valid, a_ch);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (a_valid !== 1'b0 || a_ch !== 3'd0 || a_data !== 16'd0) begin
            errors++; $display("FAIL ar_immediate: got v %b ch %0d d %h want 0 0 0", a_valid, a_ch, a_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        v = '{16'hFFF0, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80};
        for (int i = 0; i < 4; i++) begin
            send_frame(v);
            if (i < 3) gap(seen);
        end
        wait_a_valid(cyc);
        checks++; if (cyc != 9) begin errors++; $display("FAIL ar_latency: got %0d want 9", cyc); end
        for (int b = 0; b < 8; b++) begin
            checks++; if (a_data !== v[b] || a_ch !== 3'(b)) begin
                errors++; $display("FAIL ar_beat[%0d]: got %h ch %0d want %h ch %0d", b, a_data, a_ch, v[b], b);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        in_ch1 = '0; in_ch2 = '0; in_ch3 = '0; in_ch4 = '0;
        in_ch5 = '0; in_ch6 = '0; in_ch7 = '0; in_ch8 = '0;
        test_reset();
        test_passthrough();
        test_average();
        test_backpressure();
        test_overrun();
        test_clear();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
